gate_vector_decoder: RTL and testbench

//  Receive end of the 7-bit basic-gate result vector (NOT,AND,OR,NAND,NOR,XOR,XNOR of a,b).

---
 rtl/gate_vector_decoder.sv | 133 +++++++++++++
 tb/tb_gate_vector_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_decoder.sv
// Receive-side decoder for the 7-bit basic-gate result vector: recovers (a,b), flags
// vectors that do not regenerate exactly, counts traffic and tracks link lock quality.
module gate_vector_decoder #(
    parameter int CNT_W    = 16,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_M = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:6]       vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_out,
    output logic             b_out,
    output logic             err,
    output logic             locked,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int RUN_MAX = (LOCK_N > UNLOCK_M) ? LOCK_N : UNLOCK_M;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] LOCK_RUN   = RUN_W'(LOCK_N);
    localparam logic [RUN_W-1:0] UNLOCK_RUN = RUN_W'(UNLOCK_M);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_d;
    logic [RUN_W-1:0] good_run, good_d, good_inc;
    logic [RUN_W-1:0] bad_run, bad_d, bad_inc;
    logic             accept;
    logic             a_dec, b_dec, err_dec;
    logic [0:6]       exp_vec;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // a comes straight from the NOT bit; b is read from AND when a=1, from OR when a=0
    assign a_dec   = ~vec[0];
    assign b_dec   = a_dec ? vec[1] : vec[2];
    assign exp_vec = {~a_dec, a_dec & b_dec, a_dec | b_dec, ~(a_dec & b_dec),
                      ~(a_dec | b_dec), a_dec ^ b_dec, ~(a_dec ^ b_dec)};
    assign err_dec = (exp_vec != vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            a_out     <= a_dec;
            b_out     <= b_dec;
            err       <= err_dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt <= '0;
            err_cnt <= '0;
        end else if (clr) begin
            vec_cnt <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            if (vec_cnt != '1)
                vec_cnt <= vec_cnt + 1'b1;
            if (err_dec && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

    assign good_inc = good_run + 1'b1;
    assign bad_inc  = bad_run + 1'b1;

    always_comb begin
        state_d = state;
        good_d  = good_run;
        bad_d   = bad_run;
        if (clr) begin
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
        end else if (accept) begin
            case (state)
                HUNT: begin
                    if (err_dec) begin
                        good_d = '0;
                    end else if (good_inc == LOCK_RUN) begin
                        state_d = LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
                LOCKED: begin
                    if (!err_dec) begin
                        bad_d = '0;
                    end else if (bad_inc == UNLOCK_RUN) begin
                        state_d = HUNT;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_inc;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_run <= '0;
            bad_run  <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_d;
            good_run <= good_d;
            bad_run  <= bad_d;
            locked   <= (state_d == LOCKED);
        end
    end

endmodule

// File: tb/tb_gate_vector_decoder.sv
// Randomized and directed bench for gate_vector_decoder against a behavioural model.
module tb_gate_vector_decoder;

    localparam int CNT_W    = 3;
    localparam int LOCK_N   = 4;
    localparam int UNLOCK_M = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, clr, in_valid, in_ready, out_valid, out_ready;
    logic [0:6]       vec;
    logic             a_out, b_out, err, locked;
    logic [CNT_W-1:0] vec_cnt, err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic m_valid, m_a, m_b, m_err, m_locked;
    int   m_vcnt, m_ecnt, m_good, m_bad;

    gate_vector_decoder #(.CNT_W(CNT_W), .LOCK_N(LOCK_N), .UNLOCK_M(UNLOCK_M)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .vec(vec), .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out),
        .b_out(b_out), .err(err), .locked(locked), .vec_cnt(vec_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:6] gates(input logic a, input logic b);
        return {!a, a & b, a | b, !(a & b), !(a | b), a ^ b, !(a ^ b)};
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_err = 0; m_locked = 0;
        m_vcnt = 0; m_ecnt = 0; m_good = 0; m_bad = 0;
    endtask

    // Evaluated once per rising edge with the inputs that were presented before it.
    task automatic model_edge(input logic v, input logic [0:6] d, input logic r, input logic c);
        logic acc, a, b, bad;
        acc = v && (!m_valid || r);
        a   = !d[0];
        b   = a ? d[1] : d[2];
        bad = (gates(a, b) != d);
        if (acc) begin
            m_valid = 1; m_a = a; m_b = b; m_err = bad;
        end else if (r) begin
            m_valid = 0;
        end
        if (c) begin
            m_vcnt = 0; m_ecnt = 0; m_good = 0; m_bad = 0; m_locked = 0;
        end else if (acc) begin
            m_vcnt = sat(m_vcnt + 1);
            if (bad) m_ecnt = sat(m_ecnt + 1);
            m_good = bad ? 0 : m_good + 1;
            m_bad  = bad ? m_bad + 1 : 0;
            if (!m_locked && m_good >= LOCK_N) begin
                m_locked = 1; m_good = 0; m_bad = 0;
            end else if (m_locked && m_bad >= UNLOCK_M) begin
                m_locked = 0; m_good = 0; m_bad = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("a_out", a_out, m_a);
        chk("b_out", b_out, m_b);
        chk("err", err, m_err);
        chk("locked", locked, m_locked);
        chk("vec_cnt", vec_cnt, m_vcnt);
        chk("err_cnt", err_cnt, m_ecnt);
    endtask

    // Called at a falling edge; drives inputs, checks in_ready, advances one cycle.
    task automatic step(input logic v, input logic [0:6] d, input logic r, input logic c);
        in_valid = v; vec = d; out_ready = r; clr = c;
        #1 chk("in_ready", in_ready, !m_valid || r);
        @(posedge clk);
        model_edge(v, d, r, c);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [0:6] legal [4];
        logic [0:6] rv;
        logic [0:6] corrupt;
        legal[0] = 7'b1001101; legal[1] = 7'b1011010;
        legal[2] = 7'b0011010; legal[3] = 7'b0110001;
        corrupt  = 7'b0110000;

        rst_n = 0; clr = 0; in_valid = 0; out_ready = 0; vec = '0;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst_n = 1;
        @(negedge clk);

        // all four legal operand pairs
        for (int i = 0; i < 4; i++) begin
            step(1, legal[i], 1, 0);
            chk("legal_a", a_out, (i >= 2));
            chk("legal_b", b_out, i[0]);
            chk("legal_err", err, 0);
        end

        // corrupted XNOR bit
        step(1, corrupt, 1, 0);
        chk("corrupt_err", err, 1);
        chk("corrupt_errcnt", err_cnt, 1);

        // backpressure: only the first of three offered vectors is taken
        step(0, '0, 1, 1);
        step(1, legal[1], 0, 0);
        step(1, legal[2], 0, 0);
        step(1, legal[3], 0, 0);
        chk("bp_held_a", a_out, 0);
        chk("bp_held_b", b_out, 1);
        chk("bp_vec_cnt", vec_cnt, 1);
        step(0, '0, 1, 0);

        // lock after four good, unlock after bad,good,bad,bad
        step(0, '0, 1, 1);
        for (int i = 0; i < LOCK_N; i++) step(1, legal[i], 1, 0);
        chk("lock_after_4", locked, 1);
        step(1, corrupt, 1, 0);
        step(1, legal[0], 1, 0);
        step(1, corrupt, 1, 0);
        chk("still_locked", locked, 1);
        step(1, corrupt, 1, 0);
        chk("unlock", locked, 0);

        // saturation
        step(0, '0, 1, 1);
        for (int i = 0; i < 10; i++) step(1, corrupt, 1, 0);
        chk("sat_vec_cnt", vec_cnt, CNT_MAX);
        chk("sat_err_cnt", err_cnt, CNT_MAX);

        // clr with simultaneous accept: result delivered, nothing counted
        step(1, legal[3], 1, 1);
        chk("clr_vec_cnt", vec_cnt, 0);
        chk("clr_valid", out_valid, 1);
        chk("clr_a", a_out, 1);

        // randomized traffic with occasional clr and async reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 50) rv = legal[$urandom_range(3)];
            else rv = 7'($urandom);
            step($urandom_range(99) < 75, rv, $urandom_range(99) < 70,
                 $urandom_range(99) < 3);
            if (i % 150 == 149) begin
                in_valid = 1; vec = legal[3];
                #2 rst_n = 0;
                model_reset();
                #1 check_outputs();
                in_valid = 0;
                @(negedge clk);
                rst_n = 1;
                @(negedge clk);
                check_outputs();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
